// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer handshake and RAM port bundle
// for the dual-port-RAM FIFO controller.
interface dpram_fifo_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb;

  modport master (
    output wr_en, wr_data, rd_en, ram_doutb,
    input  full, almost_full, rd_data, rd_valid,
    input  empty, count, overflow, underflow,
    input  ram_ena, ram_wea, ram_addra, ram_dina,
    input  ram_enb, ram_addrb
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ram_doutb,
    output full, almost_full, rd_data, rd_valid,
    output empty, count, overflow, underflow,
    output ram_ena, ram_wea, ram_addra, ram_dina,
    output ram_enb, ram_addrb
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO sequencer driving write port A
// and read port B of a simple dual-port block RAM.
module dpram_fifo_ctrl #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int AFULL_THRESH = 240
) (
  input logic               clk,
  input logic               rst_n,
  dpram_fifo_ctrl_if.slave  bus
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL = (AW+1)'(AFULL_THRESH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          rvld;
  logic          ovf;
  logic          unf;
  logic          is_full;
  logic          is_empty;
  logic          push_ok;
  logic          pop_ok;

  assign is_full  = (cnt == DEPTH);
  assign is_empty = (cnt == '0);

  // Gating with rst_n keeps the RAM untouched while reset is held.
  assign push_ok = rst_n & bus.wr_en & ~is_full;
  assign pop_ok  = rst_n & bus.rd_en & ~is_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rvld   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      rvld <= pop_ok;
      if (bus.wr_en && is_full)  ovf <= 1'b1;
      if (bus.rd_en && is_empty) unf <= 1'b1;
    end
  end

  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.almost_full = (cnt >= AFULL);
  assign bus.count       = cnt;
  assign bus.overflow    = ovf;
  assign bus.underflow   = unf;
  assign bus.rd_valid    = rvld;
  assign bus.rd_data     = bus.ram_doutb;
  assign bus.ram_ena     = push_ok;
  assign bus.ram_wea     = push_ok;
  assign bus.ram_addra   = wr_ptr;
  assign bus.ram_dina    = bus.wr_data;
  assign bus.ram_enb     = pop_ok;
  assign bus.ram_addrb   = rd_ptr;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a
// behavioural 256x8 RAM model on ports A/B.
module tb_dpram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl_if #(.AW(8), .DW(8)) bus ();

  dpram_fifo_ctrl #(
    .AW(8), .DW(8), .AFULL_THRESH(240)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  always_ff @(posedge clk) begin
    if (bus.ram_ena && bus.ram_wea)
      mem[bus.ram_addra] <= bus.ram_dina;
    if (bus.ram_enb)
      bus.ram_doutb <= mem[bus.ram_addrb];
  end

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic       x_ena;
    logic [7:0] x_addra;
    logic       x_enb;
    logic [7:0] x_addrb;
    int         x_cnt;
    logic       x_rv;
    logic [7:0] x_rd;
  } vec_t;

  vec_t       vt [12];
  logic [7:0] q [$];
  int         wp;
  int         rp;
  logic [7:0] d;
  logic [7:0] e;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               n, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] wd,
                       input logic re);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    rst_n       = 1'b0;

    for (int i = 0; i < 5; i++)
      vt[i] = '{0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00};
    vt[5]  = '{1, 8'h11, 0, 1, 8'h00, 0, 8'h00, 1, 0, 8'h00};
    vt[6]  = '{1, 8'h22, 0, 1, 8'h01, 0, 8'h00, 2, 0, 8'h00};
    vt[7]  = '{1, 8'h33, 0, 1, 8'h02, 0, 8'h00, 3, 0, 8'h00};
    vt[8]  = '{0, 8'h00, 1, 0, 8'h00, 1, 8'h00, 2, 1, 8'h11};
    vt[9]  = '{0, 8'h00, 1, 0, 8'h00, 1, 8'h01, 1, 1, 8'h22};
    vt[10] = '{0, 8'h00, 1, 0, 8'h00, 1, 8'h02, 0, 1, 8'h33};
    vt[11] = '{0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00};

    @(negedge clk);
    drive(1, 8'hFF, 1);
    chk("rst ena", bus.ram_ena, 0);
    tick();
    tick();
    chk("rst count", bus.count, 0);
    chk("rst empty", bus.empty, 1);
    chk("rst full", bus.full, 0);
    chk("rst afull", bus.almost_full, 0);
    chk("rst rv", bus.rd_valid, 0);
    chk("rst ovf", bus.overflow, 0);
    chk("rst unf", bus.underflow, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].we, vt[i].wd, vt[i].re);
      chk($sformatf("v%0d ena", i), bus.ram_ena, vt[i].x_ena);
      chk($sformatf("v%0d wea", i), bus.ram_wea, vt[i].x_ena);
      chk($sformatf("v%0d enb", i), bus.ram_enb, vt[i].x_enb);
      if (vt[i].x_ena) begin
        chk($sformatf("v%0d addra", i), bus.ram_addra, vt[i].x_addra);
        chk($sformatf("v%0d dina", i), bus.ram_dina, vt[i].wd);
      end
      if (vt[i].x_enb)
        chk($sformatf("v%0d addrb", i), bus.ram_addrb, vt[i].x_addrb);
      tick();
      chk($sformatf("v%0d count", i), bus.count, vt[i].x_cnt);
      chk($sformatf("v%0d empty", i), bus.empty, vt[i].x_cnt == 0);
      chk($sformatf("v%0d full", i), bus.full, 0);
      chk($sformatf("v%0d rv", i), bus.rd_valid, vt[i].x_rv);
      if (vt[i].x_rv)
        chk($sformatf("v%0d rdata", i), bus.rd_data, vt[i].x_rd);
    end
    wp = 3;
    rp = 3;

    for (int i = 0; i < 256; i++) begin
      drive(1, 8'(i), 0);
      chk("fill ena", bus.ram_ena, 1);
      chk("fill addra", bus.ram_addra, wp);
      tick();
      wp = (wp + 1) % 256;
      chk("fill count", bus.count, i + 1);
      chk("fill afull", bus.almost_full, (i + 1) >= 240);
      chk("fill full", bus.full, (i + 1) == 256);
    end
    drive(1, 8'hEE, 0);
    chk("ovf ena", bus.ram_ena, 0);
    tick();
    chk("ovf flag", bus.overflow, 1);
    chk("ovf count", bus.count, 256);
    chk("ovf full", bus.full, 1);

    for (int i = 0; i < 256; i++) begin
      drive(0, 8'h00, 1);
      chk("drain enb", bus.ram_enb, 1);
      chk("drain addrb", bus.ram_addrb, rp);
      tick();
      rp = (rp + 1) % 256;
      chk("drain rv", bus.rd_valid, 1);
      chk("drain data", bus.rd_data, i);
      chk("drain count", bus.count, 255 - i);
    end
    chk("drain empty", bus.empty, 1);

    for (int i = 0; i < 5; i++) begin
      d = 8'(8'hC0 + i);
      drive(1, d, 0);
      tick();
      q.push_back(d);
    end
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom_range(0, 255));
      drive(1, d, 1);
      chk("stream ena", bus.ram_ena, 1);
      chk("stream enb", bus.ram_enb, 1);
      tick();
      q.push_back(d);
      e = q.pop_front();
      chk("stream rv", bus.rd_valid, 1);
      chk("stream data", bus.rd_data, e);
      chk("stream count", bus.count, 5);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 1);
      tick();
      e = q.pop_front();
      chk("tail data", bus.rd_data, e);
      chk("tail count", bus.count, 4 - i);
    end

    drive(0, 8'h00, 1);
    chk("unf enb", bus.ram_enb, 0);
    tick();
    chk("unf rv", bus.rd_valid, 0);
    chk("unf flag", bus.underflow, 1);
    chk("unf count", bus.count, 0);
    chk("ovf sticky", bus.overflow, 1);

    drive(1, 8'h5A, 1);
    chk("pp ena", bus.ram_ena, 1);
    chk("pp enb", bus.ram_enb, 0);
    tick();
    chk("pp count", bus.count, 1);
    chk("pp rv", bus.rd_valid, 0);

    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(i), 0);
      tick();
    end
    drive(0, 8'h00, 1);
    tick();
    chk("pre rst count", bus.count, 10);
    chk("pre rst data", bus.rd_data, 8'h5A);

    rst_n = 1'b0;
    drive(1, 8'h77, 1);
    chk("mid rst ena", bus.ram_ena, 0);
    chk("mid rst enb", bus.ram_enb, 0);
    tick();
    rst_n = 1'b1;
    chk("mid rst rv", bus.rd_valid, 0);
    chk("mid rst count", bus.count, 0);
    chk("mid rst empty", bus.empty, 1);
    chk("mid rst ovf", bus.overflow, 0);
    chk("mid rst unf", bus.underflow, 0);
    drive(0, 8'h00, 0);
    tick();
    chk("post rst rv", bus.rd_valid, 0);

    drive(1, 8'hA5, 0);
    chk("a5 addra", bus.ram_addra, 0);
    tick();
    drive(0, 8'h00, 1);
    chk("a5 addrb", bus.ram_addrb, 0);
    tick();
    chk("a5 rv", bus.rd_valid, 1);
    chk("a5 data", bus.rd_data, 8'hA5);
    chk("a5 count", bus.count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Sequencing controller that turns the 256 x 8 simple dual-port block RAM into a synchronous FIFO.
- Owns write port A and read port B of the RAM. Generates enables, addresses and write data, tracks occupancy, and returns read data with a valid strobe.
- Sits between a byte producer and a byte consumer. Both RAM clocks (clka, clkb) are tied to this block's clk at the next level up.

Parameters:
- AW, 8, address width; RAM depth = 2**AW.
- DW, 8, data width.
- AFULL_THRESH, 240, occupancy at or above which almost_full asserts.

Ports:
- clk  input  1  single clock for the controller and both RAM ports.
- rst_n  input  1  reset, synchronous, active-low.
- wr_en  input  1  push request.
- wr_data  input  DW  push data.
- full  output  1  occupancy == 2**AW.
- almost_full  output  1  occupancy >= AFULL_THRESH.
- rd_en  input  1  pop request.
- rd_data  output  DW  pop data; meaningful only while rd_valid=1.
- rd_valid  output  1  rd_data valid this cycle.
- empty  output  1  occupancy == 0.
- count  output  AW+1  current occupancy, 0..2**AW.
- overflow  output  1  sticky; push attempted while full.
- underflow  output  1  sticky; pop attempted while empty.
- ram_ena  output  1  to RAM ena.
- ram_wea  output  1  to RAM wea.
- ram_addra  output  AW  to RAM addra.
- ram_dina  output  DW  to RAM dina.
- ram_enb  output  1  to RAM enb.
- ram_addrb  output  AW  to RAM addrb.
- ram_doutb  input  DW  from RAM doutb; 1-cycle read latency, no output register.

Behaviour:
- Reset: rst_n is sampled on rising clk only (synchronous, active-low). While it is low, at each edge:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_full=0.
  - rd_valid=0, overflow=0, underflow=0.
  - No RAM write is issued.
- Reset mid-operation: an in-flight read is discarded (rd_valid=0 on the following cycle). RAM contents are not cleared.
- Accepted push: push_ok = wr_en & ~full.
  - Combinationally: ram_ena=1, ram_wea=1, ram_addra=wr_ptr, ram_dina=wr_data.
  - Next edge: wr_ptr += 1.
- Accepted pop: pop_ok = rd_en & ~empty.
  - Combinationally: ram_enb=1, ram_addrb=rd_ptr.
  - Next edge: rd_ptr += 1 and rd_valid=1.
  - rd_data = ram_doutb, passed through combinationally, so data appears the cycle after rd_en.
- rd_valid is a registered copy of pop_ok; it is 0 in every cycle not preceded by an accepted pop.
- Idle: when push_ok=0, ram_ena=0 and ram_wea=0. When pop_ok=0, ram_enb=0. Address and data outputs may then hold any value.
- Pointers are AW bits and wrap naturally 255 -> 0 with no extra state.
- count update per edge:
  - +1 on push_ok only.
  - −1 on pop_ok only.
  - Unchanged when both or neither occur.
- full, empty and almost_full are decoded from the registered count, so they change the cycle after the causing push or pop.
- Simultaneous push and pop:
  - When not empty and not full, both are accepted and count is unchanged.
  - When full, the pop is accepted and the push is rejected (full=1 at request time).
  - When empty, the push is accepted and the pop is rejected.
- No read/write address collision can occur: an accepted pop implies count >= 1, so rd_ptr != wr_ptr unless full, and when full no push is accepted.
- Rejected requests: pointers and count are unchanged and the RAM is not enabled.
  - wr_en while full sets overflow.
  - rd_en while empty sets underflow.
  - Both flags stay set until reset.
- Ordering is strict FIFO; data popped equals data pushed in order, across pointer wrap.

Test Plan:
- Reset then idle 5 cycles -> empty=1, full=0, count=0, rd_valid=0, ram_ena=ram_enb=0 every cycle.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 consecutive cycles -> ram_addra 0,1,2 with wea=1; rd_valid high on the 3 cycles after each rd_en with rd_data 0x11, 0x22, 0x33; count sequence 1,2,3,2,1,0; empty=1 at end.
- Push 256 bytes (value = index) -> full=1 after the 256th push; almost_full rises when count reaches 240. A 257th push -> no RAM write, overflow=1, count stays 256. Then pop all -> values 0..255 in order.
- Simultaneous push/pop at count=5 for 300 cycles -> count stays 5, pointers wrap past 255, popped stream equals pushed stream delayed by 5 entries.
- Pop while empty -> ram_enb=0, rd_valid=0, underflow=1. Push+pop together while empty -> only the push is accepted and count=1.
- Assert rst_n=0 for one cycle the cycle after a pop with count=10 -> next cycle rd_valid=0, count=0, empty=1, overflow/underflow cleared. A subsequent push/pop of 0xA5 reads back 0xA5 from address 0.
